// File: rtl/axil_pkg.sv
// Shared AXI4-Lite encodings: response codes and the read-arbiter state set.
// Imported by the read arbiter and by other AXI-Lite blocks.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axil_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_onehot[w_idx] = 1'b1;
        gnt_idx           = w_idx;
      end
    end
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read port (AR + R) between N_REQ
// requesters, one transaction in flight, with completion and error counters.
module axil_rd_arbiter
  import axil_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [2:0]              m_arprot,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  output logic                    busy,
  output logic [31:0]             txn_count,
  output logic [31:0]             err_count,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);

  // Every channel completes on the rising edge where valid and ready are both
  // high; valid never waits for ready, and once raised it holds with stable
  // payload until that edge.

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [N_REQ-1:0]  w_pick_onehot;
  logic              w_pick_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_accept;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_rsp_hs;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [1:0]        r_rsp_resp;
  logic [31:0]       r_txn_count;
  logic [31:0]       r_err_count;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_pick_onehot),
    .gnt_idx    (w_pick_idx),
    .any        (w_pick_any)
  );

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_onehot[i]) w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Grant is visible only in IDLE and never while reset is held.
  assign w_accept = (r_state == IDLE) && w_pick_any && !ARESET;
  assign w_ar_hs  = (r_state == ADDR) && r_arvalid && m_arready;
  assign w_r_hs   = (r_state == DATA) && r_rready && m_rvalid;
  assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_gnt];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ADDR;
      ADDR:    if (w_ar_hs)  w_next_state = DATA;
      DATA:    if (w_r_hs)   w_next_state = RESP;
      RESP:    if (w_rsp_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
      r_txn_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_gnt     <= w_pick_idx;
        r_araddr  <= w_sel_addr;
        r_arvalid <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready    <= 1'b0;
        r_rsp_data  <= m_rdata;
        r_rsp_resp  <= m_rresp;
        r_rsp_valid <= N_REQ'(1) << r_gnt;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= '0;
        r_txn_count <= r_txn_count + 32'd1;
        if (resp_is_err(r_rsp_resp)) r_err_count <= r_err_count + 32'd1;
        // Served requester drops to lowest priority for the next pick.
        r_rr_ptr <= (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
      end
    end
  end

  assign req_ready = w_accept ? w_pick_onehot : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_resp  = r_rsp_resp;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_araddr;
  assign m_arprot  = 3'b000;
  assign m_rready  = r_rready;
  assign busy      = (r_state != IDLE);
  assign txn_count = r_txn_count;
  assign err_count = r_err_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Bench for axil_rd_arbiter: AXI-Lite slave model with programmable delays,
// table-driven single transactions, corner sequences and randomized traffic.
module tb_axil_rd_arbiter;
  import axil_pkg::*;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic                    ACLK = 1'b0;
  logic                    ARESET;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [1:0]              rsp_resp;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [ADDR_W-1:0]       m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    busy;
  logic [31:0]             txn_count;
  logic [31:0]             err_count;
  logic [1:0]              dbg_state;

  axil_rd_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .busy      (busy),
    .txn_count (txn_count),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400us, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [0:1023];
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        stray_rvalid;
  int          ar_dly;
  int          r_dly;
  int          wait_a;
  int          wait_r;
  bit          r_phase;
  bit          ar_will;
  bit          r_will;
  bit          prev_arvalid;
  logic [15:0] prev_araddr;
  logic [15:0] lat_addr;
  int          ar_hs_cnt;
  int          r_hs_cnt;
  logic [15:0] ar_addr_q[$];

  assign m_arready = s_arready;
  assign m_rvalid  = s_rvalid | stray_rvalid;
  assign m_rdata   = stray_rvalid ? 32'hDEAD_BEEF : s_rdata;
  assign m_rresp   = stray_rvalid ? 2'b11 : s_rresp;

  // Address map: 0x000-0x3FF backed by mem, 0x03FF answers SLVERR, above decodes to DECERR.
  function automatic logic [33:0] slave_rsp(input logic [15:0] a);
    if (a[15:10] != 6'd0) return {2'b11, 32'h0};
    if (a == 16'h03FF)    return {2'b10, mem[a[9:0]]};
    return {2'b00, mem[a[9:0]]};
  endfunction

  initial begin
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    wait_a = 0; wait_r = 0; r_phase = 0; ar_will = 0; r_will = 0;
    prev_arvalid = 0; prev_araddr = '0; lat_addr = '0;
    ar_hs_cnt = 0; r_hs_cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        s_arready = 1'b0; s_rvalid = 1'b0;
        wait_a = 0; wait_r = 0; r_phase = 0; ar_will = 0; r_will = 0;
        prev_arvalid = 0;
      end else begin
        if (prev_arvalid && !ar_will) begin
          chk("arvalid_held", m_arvalid, 1);
          chk("araddr_stable", m_araddr, prev_araddr);
        end
        if (ar_will) begin
          s_arready = 1'b0; r_phase = 1; wait_r = 0; wait_a = 0;
          ar_hs_cnt++;
          ar_addr_q.push_back(lat_addr);
        end
        if (r_will) begin
          s_rvalid = 1'b0; r_phase = 0; r_hs_cnt++;
        end
        if (!r_phase) begin
          if (m_arvalid && !s_arready) begin
            if (wait_a >= ar_dly) s_arready = 1'b1;
            else wait_a++;
          end
        end else if (!s_rvalid) begin
          if (wait_r >= r_dly) begin
            {s_rresp, s_rdata} = slave_rsp(lat_addr);
            s_rvalid = 1'b1;
          end else begin
            wait_r++;
          end
        end
        ar_will = s_arready && m_arvalid;
        if (ar_will) lat_addr = m_araddr;
        r_will       = s_rvalid && m_rready;
        prev_arvalid = m_arvalid;
        prev_araddr  = m_araddr;
      end
    end
  end

  // ---------------- reference model state ----------------
  int          m_txn;
  int          m_err;
  int          m_ptr;
  logic [33:0] last_rsp;
  logic [35:0] exp_q[$];
  int          got_order[$];
  logic [15:0] tq [N_REQ][$];

  function automatic void model_complete(input int g, input logic [1:0] resp);
    m_txn++;
    if (resp != 2'b00) m_err++;
    m_ptr = (g + 1) % N_REQ;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_single(input int idx, input logic [15:0] addr, input int ard, input int rd,
                           input int rspd, input bit stray, input int exp_lat,
                           input logic [1:0] exp_resp);
    int          cyc;
    int          lat;
    int          ar0;
    int          r0;
    bit          got;
    logic [33:0] e;
    logic [15:0] seen;
    ar_dly = ard;
    r_dly  = rd;
    ar0 = ar_hs_cnt;
    r0  = r_hs_cnt;
    e   = slave_rsp(addr);
    @(posedge ACLK); #1;
    req_valid[idx] = 1'b1;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    got = 0; cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge ACLK);
      if (req_ready != '0) got = 1; else cyc++;
    end
    chk("accept_onehot", req_ready, N_REQ'(1) << idx);
    @(posedge ACLK); #1;
    req_valid[idx] = 1'b0;
    @(negedge ACLK);
    chk("c1_arvalid", m_arvalid, 1);
    chk("c1_araddr", m_araddr, addr);
    chk("c1_busy", busy, 1);
    lat = 1;
    if (stray) stray_rvalid = 1'b1;
    while (rsp_valid == '0 && lat < 60) begin
      @(negedge ACLK);
      lat++;
      if (stray && lat == 2) chk("stray_addr_rready", m_rready, 0);
      if (lat == 4) stray_rvalid = 1'b0;
    end
    stray_rvalid = 1'b0;
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_onehot", rsp_valid, N_REQ'(1) << idx);
    chk("rsp_data", rsp_data, e[31:0]);
    chk("rsp_resp", rsp_resp, exp_resp);
    for (int k = 0; k < rspd; k++) begin
      rsp_ready = ~(N_REQ'(1) << idx);
      @(negedge ACLK);
      chk("rsp_hold", {rsp_valid, rsp_resp, rsp_data}, {N_REQ'(1) << idx, e});
    end
    rsp_ready = N_REQ'(1) << idx;
    @(negedge ACLK);
    rsp_ready = '0;
    model_complete(idx, e[33:32]);
    last_rsp = e;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_state_idle", dbg_state, 2'd0);
    chk("txn_count", txn_count, m_txn);
    chk("err_count", err_count, m_err);
    chk("ar_hs_once", ar_hs_cnt - ar0, 1);
    chk("r_hs_once", r_hs_cnt - r0, 1);
    seen = 16'hFFFF;
    if (ar_addr_q.size() > 0) seen = ar_addr_q.pop_front();
    chk("ar_hs_addr", seen, addr);
  endtask

  // Requesters hold req_valid for as long as their queue is non-empty.
  task automatic run_traffic(input int budget);
    int               pend[N_REQ];
    int               ptr;
    int               g;
    int               cyc;
    int               wait_c;
    bit               found;
    logic [15:0]      a;
    logic [33:0]      r;
    logic [35:0]      e;
    logic [N_REQ-1:0] acc;
    ptr = m_ptr;
    for (int i = 0; i < N_REQ; i++) pend[i] = tq[i].size();
    found = 1;
    while (found) begin
      found = 0;
      g = 0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && pend[(ptr + k) % N_REQ] > 0) begin
          found = 1;
          g = (ptr + k) % N_REQ;
        end
      end
      if (found) begin
        a = tq[g][tq[g].size() - pend[g]];
        r = slave_rsp(a);
        exp_q.push_back({2'(g), r});
        pend[g]--;
        ptr = (g + 1) % N_REQ;
      end
    end
    got_order.delete();
    ar_addr_q.delete();
    @(posedge ACLK); #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (tq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = tq[i][0];
      end
    end
    cyc = 0;
    wait_c = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge ACLK);
      cyc++;
      acc = req_valid & req_ready;
      if (acc != '0) begin
        ar_dly = $urandom_range(0, 3);
        r_dly  = $urandom_range(0, 3);
        wait_c = $urandom_range(0, 2);
      end
      if (rsp_valid != '0) begin
        if (wait_c > 0) begin
          wait_c--;
          rsp_ready = ~rsp_valid & N_REQ'($urandom);
        end else begin
          rsp_ready = rsp_valid;
          e = exp_q.pop_front();
          g = 0;
          for (int i = 0; i < N_REQ; i++) if (rsp_valid[i]) g = i;
          got_order.push_back(g);
          chk("trf_gnt", rsp_valid, N_REQ'(1) << e[35:34]);
          chk("trf_rsp", {rsp_resp, rsp_data}, e[33:0]);
          model_complete(int'(e[35:34]), e[33:32]);
          last_rsp = e[33:0];
        end
      end else begin
        rsp_ready = '0;
      end
      @(posedge ACLK); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i]) begin
          void'(tq[i].pop_front());
          if (tq[i].size() > 0) req_addr[i*ADDR_W +: ADDR_W] = tq[i][0];
          else req_valid[i] = 1'b0;
        end
      end
    end
    rsp_ready = '0;
    req_valid = '0;
    chk("trf_drained", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < N_REQ; i++) tq[i].delete();
    @(negedge ACLK);
    chk("trf_txn_count", txn_count, m_txn);
    chk("trf_err_count", err_count, m_err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [15:0] addr;
    int          ar_dly;
    int          r_dly;
    int          rsp_dly;
    bit          stray;
    int          exp_lat;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  ord;
    logic [15:0] a;
    int          cyc;
    n_cmp = 0; n_fail = 0;
    m_txn = 0; m_err = 0; m_ptr = 0; last_rsp = '0;
    req_valid = '0; req_addr = '0; rsp_ready = '0; stray_rvalid = 1'b0;
    ar_dly = 0; r_dly = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    vecs[0] = '{0, 16'h0010, 0, 0, 0, 1'b0, 3,  2'b00};
    vecs[1] = '{1, 16'h0020, 5, 7, 3, 1'b0, 15, 2'b00};
    vecs[2] = '{0, 16'h03FF, 0, 0, 0, 1'b0, 3,  2'b10};
    vecs[3] = '{1, 16'h0500, 1, 2, 1, 1'b0, 6,  2'b11};
    vecs[4] = '{0, 16'h0044, 6, 0, 0, 1'b1, 9,  2'b00};
    vecs[5] = '{1, 16'h03FE, 2, 3, 2, 1'b0, 8,  2'b00};

    // Reset: all outputs low even with requests pending.
    ARESET = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outputs", {rsp_valid, m_arvalid, m_rready, busy, m_arprot}, 0);
    chk("rst_counters", {txn_count, err_count}, 0);
    chk("rst_state", dbg_state, 2'd0);
    req_valid = '0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    for (int v = 0; v < 6; v++)
      do_single(vecs[v].idx, vecs[v].addr, vecs[v].ar_dly, vecs[v].r_dly, vecs[v].rsp_dly,
                vecs[v].stray, vecs[v].exp_lat, vecs[v].exp_resp);

    // Contention: both requesters continuously valid starting from pointer 0.
    chk("pre_contention_ptr", m_ptr, 0);
    tq[0].push_back(16'h0100); tq[0].push_back(16'h0104);
    tq[1].push_back(16'h0200); tq[1].push_back(16'h0204);
    run_traffic(400);
    ord = 4'hF;
    for (int k = 0; k < 4; k++) if (k < got_order.size()) ord[k] = got_order[k][0];
    chk("contention_order", ord, 4'b1010);
    chk("contention_count", got_order.size(), 4);

    // Stray R beats while IDLE are ignored.
    @(posedge ACLK); #1;
    stray_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("stray_idle_quiet", {rsp_valid, m_rready, busy}, 0);
    end
    stray_rvalid = 1'b0;
    chk("stray_idle_data", {rsp_resp, rsp_data}, last_rsp);
    chk("stray_idle_txn", txn_count, m_txn);

    // Reset while waiting in DATA abandons the transaction.
    ar_dly = 0;
    r_dly  = 10;
    @(posedge ACLK); #1;
    req_valid[1] = 1'b1;
    req_addr[1*ADDR_W +: ADDR_W] = 16'h0123;
    cyc = 0;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
    end
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    cyc = 0;
    while (!m_rready && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("pre_reset_data_state", dbg_state, 2'd2);
    ARESET = 1'b1;
    #1;
    chk("mid_rst_ctrl", {rsp_valid, m_arvalid, m_rready, busy, req_ready}, 0);
    chk("mid_rst_counters", {txn_count, err_count}, 0);
    chk("mid_rst_rsp", {rsp_resp, rsp_data, m_araddr}, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    m_txn = 0; m_err = 0; m_ptr = 0;
    ar_addr_q.delete();
    chk("post_rst_txn", txn_count, 0);
    do_single(1, 16'h0030, 0, 0, 0, 1'b0, 3, 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < N_REQ; i++) begin
      int n;
      n = $urandom_range(5, 15);
      for (int k = 0; k < n; k++) begin
        a = 16'($urandom_range(0, 16'h04FF));
        if ($urandom_range(0, 9) == 0) a = 16'h03FF;
        tq[i].push_back(a);
      end
    end
    run_traffic(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
